// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_stream serializer slice.
// State encoding, a safe clog2 for counter sizing and the symbol parity helper.
package piso_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2
   } piso_state_e;

   // Widest symbol the parity helper accepts; narrower symbols are zero-extended.
   localparam int MAX_SYM_W = 32;

   function automatic int clog2_safe(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result++;
      end
      if (result < 1) begin
         result = 1;
      end
      return result;
   endfunction

   function automatic logic sym_parity(input logic [MAX_SYM_W-1:0] sym);
      return ^sym;
   endfunction

endpackage

// File: rtl/piso_stream_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head word is read combinationally.
// A write while full is dropped, even when a pop happens in the same cycle.
module sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     wr_en_i,
   input  logic [W-1:0]             wr_data_i,
   input  logic                     rd_en_i,
   output logic [W-1:0]             rd_data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW    = $clog2(DEPTH);
   localparam int PTR_W = AW + 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             do_wr;
   logic             do_rd;

   // Full when the wrap bits differ but the address bits match.
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign level_o = wr_ptr_q - rd_ptr_q;

   assign do_wr = wr_en_i && !full_o;
   assign do_rd = rd_en_i && !empty_o;

   assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_wr) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (do_rd) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_wr) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
      end
   end

endmodule

// File: rtl/piso_stream.sv
// Parallel-in/serial-out stage for RS symbols: FIFO in front, gap-free shifter behind.
// Define PISO_PARITY_EN to append an even-parity bit after every symbol.
module piso_stream
   import piso_pkg::*;
#(
   parameter int SYM_W      = 7,
   parameter int DEPTH      = 4,
   parameter int MSB_FIRST  = 1,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [SYM_W-1:0]         s_data_i,
   input  logic                     s_valid_i,
   output logic                     s_ready_o,
   output logic                     ser_out_o,
   output logic                     ser_en_o,
   output logic                     sym_done_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int CNT_W = clog2_safe(SYM_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SYM_W - 1);

   piso_state_e      state_q, state_d;
   logic [SYM_W-1:0] shift_q, shift_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cur_bit;
   logic             load;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [SYM_W-1:0] fifo_head;
`ifdef PISO_PARITY_EN
   logic             parity_q, parity_d;
`endif

   sync_fifo #(
      .W     (SYM_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_en_i   (s_valid_i),
      .wr_data_i (s_data_i),
      .rd_en_i   (fifo_pop),
      .rd_data_o (fifo_head),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .level_o   (level_o)
   );

   assign s_ready_o = !fifo_full;
   assign cur_bit   = (MSB_FIRST != 0) ? shift_q[SYM_W-1] : shift_q[0];

   // The last serial cycle of a symbol also loads the next one, so back-to-back symbols have no gap.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      load       = 1'b0;
      fifo_pop   = 1'b0;
      ser_en_o   = 1'b0;
      ser_out_o  = IDLE_LEVEL;
      sym_done_o = 1'b0;
`ifdef PISO_PARITY_EN
      parity_d   = parity_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               load = 1'b1;
            end
         end
         ST_SHIFT: begin
            ser_en_o  = 1'b1;
            ser_out_o = cur_bit;
            cnt_d     = cnt_q + 1'b1;
            if (MSB_FIRST != 0) begin
               shift_d = {shift_q[SYM_W-2:0], 1'b0};
            end else begin
               shift_d = {1'b0, shift_q[SYM_W-1:1]};
            end
            if (cnt_q == LAST_BIT) begin
`ifdef PISO_PARITY_EN
               state_d = ST_PARITY;
`else
               sym_done_o = 1'b1;
               if (!fifo_empty) begin
                  load = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
`endif
            end
         end
`ifdef PISO_PARITY_EN
         ST_PARITY: begin
            ser_en_o   = 1'b1;
            ser_out_o  = parity_q;
            sym_done_o = 1'b1;
            if (!fifo_empty) begin
               load = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (load) begin
         fifo_pop = 1'b1;
         shift_d  = fifo_head;
         cnt_d    = '0;
         state_d  = ST_SHIFT;
`ifdef PISO_PARITY_EN
         parity_d = sym_parity(MAX_SYM_W'(fifo_head));
`endif
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef PISO_PARITY_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end
`endif

endmodule

// File: tb/tb_piso_stream.sv
// Directed self-checking bench for piso_stream (MSB-first and LSB-first instances).
// Also exercises the parity bit when compiled with PISO_PARITY_EN.
module tb_piso_stream;

   localparam int SYM_W = 7;
   localparam int DEPTH = 4;
`ifdef PISO_PARITY_EN
   localparam int BITS = SYM_W + 1;
`else
   localparam int BITS = SYM_W;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic [SYM_W-1:0] sData, lsbData;
   logic             sValid, lsbValid;
   logic             sReady, serOut, serEn, symDone;
   logic             lsbReady, lsbSerOut, lsbSerEn, lsbSymDone;
   logic [2:0]       level, lsbLevel;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   strayDone = 0;
   logic bitQ[$];
   logic doneQ[$];
   int   enCycQ[$];
   logic lsbBitQ[$];

   always #5 clk = ~clk;

   piso_stream #(.SYM_W(SYM_W), .DEPTH(DEPTH), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) dut (
      .clk_i(clk), .rst_i(rst), .s_data_i(sData), .s_valid_i(sValid), .s_ready_o(sReady),
      .ser_out_o(serOut), .ser_en_o(serEn), .sym_done_o(symDone), .level_o(level)
   );

   piso_stream #(.SYM_W(SYM_W), .DEPTH(DEPTH), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) dutLsb (
      .clk_i(clk), .rst_i(rst), .s_data_i(lsbData), .s_valid_i(lsbValid), .s_ready_o(lsbReady),
      .ser_out_o(lsbSerOut), .ser_en_o(lsbSerEn), .sym_done_o(lsbSymDone), .level_o(lsbLevel)
   );

   // Cycle counter used to prove the serial stream is contiguous.
   always @(posedge clk) cyc <= cyc + 1;

   // Capture every qualified serial bit away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (serEn) begin
            bitQ.push_back(serOut);
            doneQ.push_back(symDone);
            enCycQ.push_back(cyc);
         end else if (symDone) begin
            strayDone++;
         end
         if (lsbSerEn) begin
            lsbBitQ.push_back(lsbSerOut);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [SYM_W-1:0] sym);
      sData  = sym;
      sValid = 1'b1;
      @(posedge clk);
      #1 sValid = 1'b0;
   endtask

   task automatic clearCapture();
      bitQ.delete();
      doneQ.delete();
      enCycQ.delete();
      lsbBitQ.delete();
      strayDone = 0;
   endtask

   task automatic waitIdle(input string tag);
      int n = 0;
      while ((serEn || level != 0) && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      checkOutput({tag, "_idle_reached"}, (n < 200), 1);
      @(posedge clk);
      #1;
   endtask

   task automatic checkSymbol(input string tag, input int idx, input logic [SYM_W-1:0] expWord,
                              input logic expPar);
      logic [SYM_W-1:0] w = '0;
      if (bitQ.size() < (idx + 1) * BITS) begin
         checkOutput({tag, "_missing"}, bitQ.size(), (idx + 1) * BITS);
      end else begin
         for (int b = 0; b < SYM_W; b++) begin
            w = {w[SYM_W-2:0], bitQ[idx*BITS+b]};
         end
         checkOutput({tag, "_data"}, w, expWord);
`ifdef PISO_PARITY_EN
         checkOutput({tag, "_parity"}, bitQ[idx*BITS+SYM_W], expPar);
`else
         if (expPar === 1'bx) $display("[TB] note: unknown parity for %s", tag);
`endif
      end
   endtask

   task automatic checkDone(input string tag, input int nSyms);
      int good = 0;
      int bad = 0;
      for (int i = 0; i < doneQ.size(); i++) begin
         if (doneQ[i]) begin
            if (i % BITS == BITS - 1) good++;
            else bad++;
         end
      end
      checkOutput({tag, "_count"}, good, nSyms);
      checkOutput({tag, "_stray"}, bad + strayDone, 0);
   endtask

   initial begin
      logic [SYM_W-1:0] syms [6];
      int               acceptEdge [6];
      int               idx, edgeIdx, refused, n;
      logic             rdy, sawFull;
      logic [SYM_W-1:0] w;

      rst = 1'b1;
      sValid = 1'b0;
      sData = '0;
      lsbValid = 1'b0;
      lsbData = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_s_ready", sReady, 1);
      checkOutput("rst_ser_out", serOut, 0);
      checkOutput("rst_ser_en", serEn, 0);
      checkOutput("rst_sym_done", symDone, 0);
      checkOutput("rst_level", level, 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;

      // Test 1: single 7'h55, MSB first -> 1010101, first bit after edge k+1
      clearCapture();
      applyStimulus(7'h55);
      @(negedge clk);
      checkOutput("t1_lat_k", serEn, 0);
      @(negedge clk);
      checkOutput("t1_lat_k1", serEn, 1);
      checkOutput("t1_first_bit", serOut, 1);
      waitIdle("t1");
      checkOutput("t1_bits", bitQ.size(), BITS);
      checkSymbol("t1", 0, 7'b1010101, 1'b0);
      checkDone("t1_done", 1);
      checkOutput("t1_idle_out", serOut, 0);

      // Tests 2/3: held s_valid burst, fill to full, refused writes, accept after pop
      clearCapture();
      syms = '{7'h12, 7'h34, 7'h56, 7'h78, 7'h1A, 7'h2B};
      acceptEdge = '{default: -1};
      idx = 0;
      edgeIdx = 0;
      refused = 0;
      sawFull = 1'b0;
      sValid = 1'b1;
      while (idx < 6 && edgeIdx < 60) begin
         sData = syms[idx];
         @(negedge clk);
         rdy = sReady;
         if (level == 3'd4 && !sReady) sawFull = 1'b1;
         @(posedge clk);
         if (rdy) begin
            acceptEdge[idx] = edgeIdx;
            idx++;
         end else begin
            refused++;
         end
         edgeIdx++;
         #1;
      end
      sValid = 1'b0;
      checkOutput("t2_all_accepted", idx, 6);
      checkOutput("t2_full_seen", sawFull, 1);
      checkOutput("t3_accept5_edge", acceptEdge[4], 4);
      checkOutput("t3_accept6_edge", acceptEdge[5], BITS + 2);
      checkOutput("t3_refused", refused, BITS - 3);
      waitIdle("t2");
      checkOutput("t2_bits", bitQ.size(), 6 * BITS);
      if (enCycQ.size() > 0) begin
         checkOutput("t2_contiguous", enCycQ[enCycQ.size()-1] - enCycQ[0] + 1, enCycQ.size());
      end else begin
         checkOutput("t2_contiguous", 0, 6 * BITS);
      end
      checkSymbol("t2_s0", 0, 7'h12, 1'b0);
      checkSymbol("t2_s1", 1, 7'h34, 1'b1);
      checkSymbol("t2_s2", 2, 7'h56, 1'b0);
      checkSymbol("t2_s3", 3, 7'h78, 1'b0);
      checkSymbol("t3_s4", 4, 7'h1A, 1'b1);
      checkSymbol("t3_s5", 5, 7'h2B, 1'b0);
      checkDone("t2_done", 6);

      // Test 4: LSB-first instance with 7'h01 -> 1 then six 0s
      clearCapture();
      lsbData = 7'h01;
      lsbValid = 1'b1;
      @(posedge clk);
      #1 lsbValid = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      checkOutput("t4_bits", lsbBitQ.size(), BITS);
      if (lsbBitQ.size() >= SYM_W) begin
         w = '0;
         for (int b = 0; b < SYM_W; b++) w = {w[SYM_W-2:0], lsbBitQ[b]};
         checkOutput("t4_order", w, 7'b1000000);
`ifdef PISO_PARITY_EN
         if (lsbBitQ.size() >= BITS) checkOutput("t4_parity", lsbBitQ[SYM_W], 1);
`endif
      end
      checkOutput("t4_idle_out", lsbSerOut, 0);
      checkOutput("t4_idle_en", lsbSerEn, 0);
      @(posedge clk);
      #1;

      // Test 5: reset during bit 3 of a symbol with two more queued
      clearCapture();
      applyStimulus(7'h7F);
      applyStimulus(7'h7F);
      applyStimulus(7'h7F);
      n = 0;
      while (bitQ.size() < 3 && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      checkOutput("t5_pre_level", level, 2);
      checkOutput("t5_pre_en", serEn, 1);
      rst = 1'b1;
      #1;
      checkOutput("t5_rst_en", serEn, 0);
      checkOutput("t5_rst_level", level, 0);
      checkOutput("t5_rst_ready", sReady, 1);
      checkOutput("t5_rst_out", serOut, 0);
      @(posedge clk);
      @(negedge clk) rst = 1'b0;
      clearCapture();
      repeat (30) @(negedge clk);
      #1;
      checkOutput("t5_no_bits", bitQ.size(), 0);
      checkOutput("t5_level_after", level, 0);
      @(posedge clk);
      #1;

`ifdef PISO_PARITY_EN
      // Test 6: parity of 7'h07 is 1, sym_done on the 8th cycle
      clearCapture();
      applyStimulus(7'h07);
      waitIdle("t6");
      checkOutput("t6_bits", bitQ.size(), 8);
      checkSymbol("t6", 0, 7'h07, 1'b1);
      checkDone("t6_done", 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
